// File: rtl/sample_ring_ctrl.sv
// +-----------------------------------------------------------------------------+
// | sample_ring_ctrl : sample ring buffer with watermark throttling of the      |
// |                    producer, tick-paced pop to DAC and Avalon-ST stream.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sample_ring_ctrl #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 24,
   parameter int HI_WM = 112,
   parameter int LO_WM = 64
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          i_tick,
   input  logic          i_rdy,
   input  logic [DW-1:0] i_sample,
   output logic          o_clk_en,
   output logic [DW-1:0] o_dac_sample,
   output logic [31:0]   aso_ss0_data,
   output logic          aso_ss0_valid,
   input  logic          aso_ss0_ready,
   output logic [AW:0]   o_level,
   input  logic          i_clr_cnt,
   output logic [15:0]   o_ovf_cnt,
   output logic [15:0]   o_unf_cnt
);

   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_HI   = (AW+1)'(HI_WM);
   localparam logic [AW:0] c_LO   = (AW+1)'(LO_WM);
   localparam logic [15:0] c_SAT  = 16'hFFFF;

   typedef enum logic [1:0] {
      S_PRIME = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   logic [DW-1:0] r_mem [DEPTH];

   state_t        r_state;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic          r_clk_en;
   logic [DW-1:0] r_dac;
   logic [31:0]   r_ss_data;
   logic          r_ss_valid;
   logic [15:0]   r_ovf_cnt;
   logic [15:0]   r_unf_cnt;

   logic          w_full;
   logic          w_empty;
   logic          w_active;
   logic          w_push;
   logic          w_ovf;
   logic          w_pop;
   logic          w_unf;
   logic          w_beat;
   logic [DW-1:0] w_rd_data;
   logic [31:0]   w_rd_sext;
   logic [AW:0]   w_level_nxt;
   state_t        w_state_nxt;

   // Full/empty are judged on the pre-cycle level, so a same-cycle pop never makes room.
   assign w_full    = (r_level == c_FULL);
   assign w_empty   = (r_level == '0);
   assign w_active  = (r_state != S_PRIME);
   assign w_push    = i_rdy & ~w_full;
   assign w_ovf     = i_rdy & w_full;
   assign w_pop     = i_tick & w_active & ~w_empty;
   assign w_unf     = i_tick & w_active & w_empty;
   assign w_beat    = w_pop & (~r_ss_valid | aso_ss0_ready);
   assign w_rd_data = r_mem[r_rptr];
   assign w_rd_sext = {{(32-DW){w_rd_data[DW-1]}}, w_rd_data};

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + (AW+1)'(1);
         2'b01:   w_level_nxt = r_level - (AW+1)'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_unf) begin
         w_state_nxt = S_PRIME;
      end else begin
         case (r_state)
            S_PRIME,
            S_RUN:   if (w_level_nxt >= c_HI) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_level_nxt <= c_LO) w_state_nxt = S_RUN;
            default: w_state_nxt = S_PRIME;
         endcase
      end
   end

   // Storage has no reset; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_sample;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= S_PRIME;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_clk_en   <= 1'b0;
         r_dac      <= '0;
         r_ss_data  <= '0;
         r_ss_valid <= 1'b0;
         r_ovf_cnt  <= '0;
         r_unf_cnt  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_level  <= w_level_nxt;
         r_clk_en <= (w_state_nxt != S_HOLD);

         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
            r_dac  <= w_rd_data;
         end

         // A beat blocked by a stalled sink is dropped; the pending beat stays intact.
         if (w_beat) begin
            r_ss_data  <= w_rd_sext;
            r_ss_valid <= 1'b1;
         end else if (r_ss_valid && aso_ss0_ready && !w_pop) begin
            r_ss_valid <= 1'b0;
         end

         if (i_clr_cnt) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
         end else begin
            if (w_ovf && r_ovf_cnt != c_SAT) r_ovf_cnt <= r_ovf_cnt + 16'd1;
            if (w_unf && r_unf_cnt != c_SAT) r_unf_cnt <= r_unf_cnt + 16'd1;
         end
      end
   end

   assign o_clk_en      = r_clk_en;
   assign o_dac_sample  = r_dac;
   assign aso_ss0_data  = r_ss_data;
   assign aso_ss0_valid = r_ss_valid;
   assign o_level       = r_level;
   assign o_ovf_cnt     = r_ovf_cnt;
   assign o_unf_cnt     = r_unf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sample_ring_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_sample_ring_ctrl : self-checking bench for sample_ring_ctrl.             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_sample_ring_ctrl;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        i_tick = 1'b0;
   logic        i_rdy = 1'b0;
   logic [23:0] i_sample = '0;
   logic        o_clk_en;
   logic [23:0] o_dac_sample;
   logic [31:0] aso_ss0_data;
   logic        aso_ss0_valid;
   logic        aso_ss0_ready = 1'b1;
   logic [7:0]  o_level;
   logic        i_clr_cnt = 1'b0;
   logic [15:0] o_ovf_cnt;
   logic [15:0] o_unf_cnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          m_level;
   int          m_st;      // 0 PRIME, 1 RUN, 2 HOLD
   logic        m_clken;
   logic        m_valid;
   logic [31:0] m_data;
   logic [23:0] m_dac;
   int          m_ovf;
   int          m_unf;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   sample_ring_ctrl dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .i_tick        (i_tick),
      .i_rdy         (i_rdy),
      .i_sample      (i_sample),
      .o_clk_en      (o_clk_en),
      .o_dac_sample  (o_dac_sample),
      .aso_ss0_data  (aso_ss0_data),
      .aso_ss0_valid (aso_ss0_valid),
      .aso_ss0_ready (aso_ss0_ready),
      .o_level       (o_level),
      .i_clr_cnt     (i_clr_cnt),
      .o_ovf_cnt     (o_ovf_cnt),
      .o_unf_cnt     (o_unf_cnt)
   );

   function automatic logic [31:0] sx(input logic [23:0] v);
      return {{8{v[23]}}, v};
   endfunction

   task automatic model_reset();
      m_level = 0; m_st = 0; m_clken = 1'b0; m_valid = 1'b0;
      m_data = '0; m_dac = '0; m_ovf = 0; m_unf = 0;
      sb.delete();
   endtask

   // One clock of stimulus; the model advances alongside the DUT.
   task automatic cycle(input logic rdy_v, input logic [23:0] s, input logic tick_v,
                        input logic clr_v);
      logic push, ovf, pop, unf;
      i_rdy = rdy_v; i_sample = s; i_tick = tick_v; i_clr_cnt = clr_v;
      push = rdy_v && (m_level != 128);
      ovf  = rdy_v && (m_level == 128);
      pop  = tick_v && (m_st != 0) && (m_level != 0);
      unf  = tick_v && (m_st != 0) && (m_level == 0);
      if (push) sb.push_back(s);
      if (pop) begin
         m_dac = sb.pop_front();
         if (!m_valid || aso_ss0_ready) begin
            m_data  = sx(m_dac);
            m_valid = 1'b1;
         end
      end else if (m_valid && aso_ss0_ready) begin
         m_valid = 1'b0;
      end
      m_level = m_level + int'(push) - int'(pop);
      if (unf)                                m_st = 0;
      else if (m_st != 2 && m_level >= 112)   m_st = 2;
      else if (m_st == 2 && m_level <= 64)    m_st = 1;
      m_clken = (m_st != 2);
      if (clr_v) begin
         m_ovf = 0; m_unf = 0;
      end else begin
         if (ovf && m_ovf < 65535) m_ovf++;
         if (unf && m_unf < 65535) m_unf++;
      end
      @(posedge clk); #1;
      i_rdy = 1'b0; i_tick = 1'b0; i_clr_cnt = 1'b0;
   endtask

   task automatic reset_dut();
      @(posedge clk); #3;
      n_rst = 1'b0;
      @(negedge clk); #2;
      n_rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({o_clk_en, o_dac_sample, aso_ss0_data, aso_ss0_valid, o_level, o_ovf_cnt, o_unf_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: clk_en=%0b dac=%0h data=%0h valid=%0b level=%0d ovf=%0d unf=%0d, required all 0",
                  o_clk_en, o_dac_sample, aso_ss0_data, aso_ss0_valid, o_level, o_ovf_cnt, o_unf_cnt);
      end
      n_rst = 1'b1;
      cycle(1'b0, 24'd0, 1'b0, 1'b0);
      checks++;
      if (o_clk_en !== 1'b1 || o_level !== 8'd0) begin
         errors++;
         $display("FAIL reset_first_edge: clk_en=%0b level=%0d, required clk_en=1 level=0", o_clk_en, o_level);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 130; i++) begin
         cycle(1'b1, 24'(i), 1'b0, 1'b0);
         checks++;
         if (o_level !== 8'(m_level) || o_clk_en !== m_clken) begin
            errors++;
            $display("FAIL fill_step%0d: level=%0d clk_en=%0b, required level=%0d clk_en=%0b",
                     i, o_level, o_clk_en, m_level, m_clken);
         end
         if (i == 111) begin
            checks++;
            if (o_level !== 8'd112 || o_clk_en !== 1'b0) begin
               errors++;
               $display("FAIL fill_hi_wm: level=%0d clk_en=%0b, required 112 and 0", o_level, o_clk_en);
            end
         end
      end
      checks++;
      if (o_ovf_cnt !== 16'd2 || o_level !== 8'd128) begin
         errors++;
         $display("FAIL fill_overflow: ovf=%0d level=%0d, required 2 and 128", o_ovf_cnt, o_level);
      end
   endtask

   task automatic test_drain_to_lo();
      reset_dut();
      for (int i = 0; i < 112; i++) cycle(1'b1, 24'(i), 1'b0, 1'b0);
      cycle(1'b0, 24'd0, 1'b0, 1'b0);
      checks++;
      if (o_level !== 8'd112 || o_clk_en !== 1'b0) begin
         errors++;
         $display("FAIL hold_entry: level=%0d clk_en=%0b, required 112 and 0", o_level, o_clk_en);
      end
      for (int k = 0; k < 48; k++) begin
         cycle(1'b0, 24'd0, 1'b1, 1'b0);
         checks++;
         if (o_dac_sample !== 24'(k) || o_dac_sample !== m_dac ||
             aso_ss0_valid !== 1'b1 || aso_ss0_data !== sx(24'(k))) begin
            errors++;
            $display("FAIL pop%0d: dac=%0h valid=%0b data=%0h, required dac=%0h valid=1 data=%0h",
                     k, o_dac_sample, aso_ss0_valid, aso_ss0_data, k, sx(24'(k)));
         end
         cycle(1'b0, 24'd0, 1'b0, 1'b0);
         checks++;
         if (aso_ss0_valid !== 1'b0 || o_clk_en !== (k == 47)) begin
            errors++;
            $display("FAIL pop%0d_after: valid=%0b clk_en=%0b, required valid=0 clk_en=%0b",
                     k, aso_ss0_valid, o_clk_en, (k == 47));
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 36; j++) cycle(1'b1, 24'(1000 + j), 1'b0, 1'b0);
      cycle(1'b1, 24'd2000, 1'b1, 1'b0);
      checks++;
      if (o_level !== 8'd100 || o_dac_sample !== 24'd48 || o_dac_sample !== m_dac) begin
         errors++;
         $display("FAIL push_pop_same: level=%0d dac=%0d, required level=100 dac=48", o_level, o_dac_sample);
      end
      for (int j = 0; j < 28; j++) cycle(1'b1, 24'(1036 + j), 1'b0, 1'b0);
      checks++;
      if (o_level !== 8'd128 || o_clk_en !== 1'b0) begin
         errors++;
         $display("FAIL refill_full: level=%0d clk_en=%0b, required 128 and 0", o_level, o_clk_en);
      end
      cycle(1'b1, 24'd3000, 1'b1, 1'b0);
      checks++;
      if (o_level !== 8'd127 || o_ovf_cnt !== 16'd1 || o_dac_sample !== 24'd49) begin
         errors++;
         $display("FAIL full_push_pop: level=%0d ovf=%0d dac=%0d, required 127, 1, 49",
                  o_level, o_ovf_cnt, o_dac_sample);
      end
   endtask

   task automatic test_underrun();
      logic [23:0] last;
      for (int k = 0; k < 127; k++) begin
         cycle(1'b0, 24'd0, 1'b1, 1'b0);
         checks++;
         if (o_dac_sample !== m_dac || o_level !== 8'(m_level)) begin
            errors++;
            $display("FAIL drain%0d: dac=%0d level=%0d, required dac=%0d level=%0d",
                     k, o_dac_sample, o_level, m_dac, m_level);
         end
         cycle(1'b0, 24'd0, 1'b0, 1'b0);
      end
      last = o_dac_sample;
      checks++;
      if (o_level !== 8'd0 || last !== 24'd1063 || o_clk_en !== 1'b1) begin
         errors++;
         $display("FAIL drained: level=%0d dac=%0d clk_en=%0b, required 0, 1063, 1", o_level, last, o_clk_en);
      end
      cycle(1'b0, 24'd0, 1'b1, 1'b0);
      checks++;
      if (o_unf_cnt !== 16'd1 || o_dac_sample !== last || aso_ss0_valid !== 1'b0) begin
         errors++;
         $display("FAIL underrun: unf=%0d dac=%0d valid=%0b, required 1, %0d, 0",
                  o_unf_cnt, o_dac_sample, aso_ss0_valid, last);
      end
      cycle(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
      cycle(1'b1, 24'h800000, 1'b0, 1'b0);
      cycle(1'b0, 24'd0, 1'b1, 1'b0);
      checks++;
      if (o_level !== 8'd2 || o_dac_sample !== last || o_unf_cnt !== 16'd1 || aso_ss0_valid !== 1'b0) begin
         errors++;
         $display("FAIL prime_tick: level=%0d dac=%0d unf=%0d valid=%0b, required 2, %0d, 1, 0",
                  o_level, o_dac_sample, o_unf_cnt, aso_ss0_valid, last);
      end
   endtask

   task automatic test_backpressure();
      for (int j = 0; j < 110; j++) cycle(1'b1, 24'(4000 + j), 1'b0, 1'b0);
      aso_ss0_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 24'd0, 1'b1, 1'b0);
         cycle(1'b0, 24'd0, 1'b0, 1'b0);
         checks++;
         if (aso_ss0_valid !== 1'b1 || aso_ss0_data !== 32'hFFFFFFFF ||
             o_dac_sample !== m_dac || aso_ss0_data !== m_data) begin
            errors++;
            $display("FAIL stall_tick%0d: valid=%0b data=%0h dac=%0h, required valid=1 data=ffffffff dac=%0h",
                     k, aso_ss0_valid, aso_ss0_data, o_dac_sample, m_dac);
         end
      end
      checks++;
      if (o_dac_sample !== 24'd4000) begin
         errors++;
         $display("FAIL stall_dac: dac=%0d, required 4000", o_dac_sample);
      end
      aso_ss0_ready = 1'b1;
      cycle(1'b0, 24'd0, 1'b0, 1'b0);
      checks++;
      if (aso_ss0_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: valid=%0b, required 0", aso_ss0_valid);
      end
   endtask

   task automatic test_async_reset_and_clear();
      for (int j = 0; j < 4; j++) cycle(1'b1, 24'(7000 + j), 1'b1, 1'b0);
      @(posedge clk); #3;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({o_clk_en, o_dac_sample, aso_ss0_data, aso_ss0_valid, o_level, o_ovf_cnt, o_unf_cnt} !== '0) begin
         errors++;
         $display("FAIL async_reset: clk_en=%0b dac=%0h data=%0h valid=%0b level=%0d ovf=%0d unf=%0d, required all 0",
                  o_clk_en, o_dac_sample, aso_ss0_data, aso_ss0_valid, o_level, o_ovf_cnt, o_unf_cnt);
      end
      @(negedge clk); #2;
      n_rst = 1'b1;
      model_reset();
      for (int j = 0; j < 112; j++) cycle(1'b1, 24'(500 + j), 1'b0, 1'b0);
      cycle(1'b0, 24'd0, 1'b1, 1'b0);
      checks++;
      if (o_dac_sample !== 24'd500 || o_dac_sample !== m_dac || o_level !== 8'd111) begin
         errors++;
         $display("FAIL restart_ring: dac=%0d level=%0d, required 500 and 111", o_dac_sample, o_level);
      end
      for (int j = 0; j < 17; j++) cycle(1'b1, 24'(600 + j), 1'b0, 1'b0);
      cycle(1'b1, 24'd0, 1'b0, 1'b0);
      checks++;
      if (o_ovf_cnt !== 16'd1 || o_ovf_cnt !== 16'(m_ovf) || o_level !== 8'd128) begin
         errors++;
         $display("FAIL ovf_before_clr: ovf=%0d level=%0d, required 1 and 128", o_ovf_cnt, o_level);
      end
      cycle(1'b1, 24'd0, 1'b0, 1'b1);
      checks++;
      if (o_ovf_cnt !== 16'd0 || o_unf_cnt !== 16'd0) begin
         errors++;
         $display("FAIL clr_wins: ovf=%0d unf=%0d, required 0 and 0", o_ovf_cnt, o_unf_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain_to_lo();
      test_back_to_back();
      test_underrun();
      test_backpressure();
      test_async_reset_and_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
